// File: rtl/rvfi_mon_pkg.sv
// Shared types for the RVFI retirement monitor: error codes, trace record
// layout, FSM states and the store-mask legality helper.
package rvfi_mon_pkg;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_PC_CHAIN = 3'd1,
      ERR_X0_WRITE = 3'd2,
      ERR_PC_ALIGN = 3'd3,
      ERR_WMASK    = 3'd4
   } err_e;

   // Compact trace record, 101 bits, MSB first: pc, insn, rd, rd data.
   typedef struct packed {
      logic [31:0] pc_rdata;
      logic [31:0] insn;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
   } trace_rec_t;

   localparam int TRACE_W = $bits(trace_rec_t);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_ERR
   } mon_state_e;

   // Naturally aligned byte, halfword and word stores, or no store at all.
   function automatic logic wmask_legal(input logic [3:0] mask);
      logic legal;
      case (mask)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
         default:                   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/mon_sync_fifo.sv
// Single-clock FIFO, registered read side (no fall-through), async reset,
// synchronous clear. Pointers carry one extra wrap bit to tell full from empty.
module mon_sync_fifo #(
   parameter int WIDTH = 101,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A pop frees the slot the simultaneous push lands in, so full+pop accepts.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Head is forced to zero while empty so stale storage never leaks out.
   assign rdata_o = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

   // Pointer update: clear empties the FIFO without touching storage.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage write.
   // NOTE: the array is deliberately not reset; pointers alone define validity, which keeps it RAM-mappable.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/rvfi_retire_monitor.sv
// RVFI retirement monitor: checks PC chain, x0 writes, PC alignment and store
// mask legality, counts retirements and buffers trace records in a FIFO.
module rvfi_retire_monitor
   import rvfi_mon_pkg::*;
#(
   parameter int          DEPTH    = 16,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear_i,
   input  logic                rvfi_valid_i,
   input  logic [31:0]         rvfi_insn_i,
   input  logic [31:0]         rvfi_pc_rdata_i,
   input  logic [31:0]         rvfi_pc_wdata_i,
   input  logic [4:0]          rvfi_rd_addr_i,
   input  logic [31:0]         rvfi_rd_wdata_i,
   input  logic [3:0]          rvfi_mem_wmask_i,
   output logic                trc_valid_o,
   input  logic                trc_ready_i,
   output logic [TRACE_W-1:0]  trc_data_o,
   output logic [31:0]         retired_o,
   output logic                overflow_o,
   output logic                error_o,
   output logic [2:0]          error_code_o,
   output logic [31:0]         error_pc_o
);

   mon_state_e  state_q, state_d;
   logic [31:0] exp_pc_q;
   logic [31:0] retired_q;
   logic        overflow_q;
   logic        error_q;
   err_e        err_code_q;
   logic [31:0] err_pc_q;
   err_e        chk_code;
   logic        new_err;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_push;
   logic        fifo_pop;
   trace_rec_t  rec;

   // Invariant checks in priority order; the first failing one names the error.
   always_comb begin
      // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
      chk_code = ERR_NONE;
      if (rvfi_pc_rdata_i != exp_pc_q)
         chk_code = ERR_PC_CHAIN;
      else if (rvfi_rd_addr_i == 5'd0 && rvfi_rd_wdata_i != 32'd0)
         chk_code = ERR_X0_WRITE;
      else if (rvfi_pc_rdata_i[1:0] != 2'b00 || rvfi_pc_wdata_i[1:0] != 2'b00)
         chk_code = ERR_PC_ALIGN;
      else if (!wmask_legal(rvfi_mem_wmask_i))
         chk_code = ERR_WMASK;
   end

   // Clear wins over a same-cycle retirement; ERR freezes the first violation.
   assign new_err = rvfi_valid_i && !clear_i && (state_q != S_ERR) && (chk_code != ERR_NONE);

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (clear_i)
         state_d = S_IDLE;
      else if (rvfi_valid_i && state_q != S_ERR)
         state_d = (chk_code != ERR_NONE) ? S_ERR : S_RUN;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Expected PC follows pc_wdata of every retirement, good or bad.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   exp_pc_q <= RESET_PC;
      else if (clear_i)          exp_pc_q <= RESET_PC;
      else if (rvfi_valid_i)     exp_pc_q <= rvfi_pc_wdata_i;
   end

   // Retirement counter, counted ahead of the FIFO so drops are included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   retired_q <= '0;
      else if (clear_i)          retired_q <= '0;
      else if (rvfi_valid_i)     retired_q <= retired_q + 32'd1;
   end

   // Sticky first-error capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
         err_pc_q   <= '0;
      end else if (clear_i) begin
         error_q    <= 1'b0;
         err_code_q <= ERR_NONE;
         err_pc_q   <= '0;
      end else if (new_err) begin
         error_q    <= 1'b1;
         err_code_q <= chk_code;
         err_pc_q   <= rvfi_pc_rdata_i;
      end
   end

   // Sticky overflow: a retirement arrived while full and nothing drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      overflow_q <= 1'b0;
      else if (clear_i)                             overflow_q <= 1'b0;
      else if (rvfi_valid_i && fifo_full && !fifo_pop) overflow_q <= 1'b1;
   end

   assign rec.pc_rdata = rvfi_pc_rdata_i;
   assign rec.insn     = rvfi_insn_i;
   assign rec.rd_addr  = rvfi_rd_addr_i;
   assign rec.rd_wdata = rvfi_rd_wdata_i;

   assign fifo_push = rvfi_valid_i && !clear_i;
   assign fifo_pop  = trc_valid_o && trc_ready_i;

   mon_sync_fifo #(
      .WIDTH (TRACE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (rec),
      .rdata_o (trc_data_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign trc_valid_o  = !fifo_empty;
   assign retired_o    = retired_q;
   assign overflow_o   = overflow_q;
   assign error_o      = error_q;
   assign error_code_o = err_code_q;
   assign error_pc_o   = err_pc_q;

endmodule

// File: tb/tb_rvfi_retire_monitor.sv
// Self-checking bench: a queue-based reference model tracks the expected
// monitor outputs; a negedge compare process checks every cycle.
module tb_rvfi_retire_monitor;
   import rvfi_mon_pkg::*;

   localparam int DEPTH = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         clear_i;
   logic         rvfi_valid_i;
   logic [31:0]  rvfi_insn_i;
   logic [31:0]  rvfi_pc_rdata_i;
   logic [31:0]  rvfi_pc_wdata_i;
   logic [4:0]   rvfi_rd_addr_i;
   logic [31:0]  rvfi_rd_wdata_i;
   logic [3:0]   rvfi_mem_wmask_i;
   logic         trc_valid_o;
   logic         trc_ready_i;
   logic [100:0] trc_data_o;
   logic [31:0]  retired_o;
   logic         overflow_o;
   logic         error_o;
   logic [2:0]   error_code_o;
   logic [31:0]  error_pc_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rvfi_retire_monitor #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk              (clk),
      .rst              (rst),
      .clear_i          (clear_i),
      .rvfi_valid_i     (rvfi_valid_i),
      .rvfi_insn_i      (rvfi_insn_i),
      .rvfi_pc_rdata_i  (rvfi_pc_rdata_i),
      .rvfi_pc_wdata_i  (rvfi_pc_wdata_i),
      .rvfi_rd_addr_i   (rvfi_rd_addr_i),
      .rvfi_rd_wdata_i  (rvfi_rd_wdata_i),
      .rvfi_mem_wmask_i (rvfi_mem_wmask_i),
      .trc_valid_o      (trc_valid_o),
      .trc_ready_i      (trc_ready_i),
      .trc_data_o       (trc_data_o),
      .retired_o        (retired_o),
      .overflow_o       (overflow_o),
      .error_o          (error_o),
      .error_code_o     (error_code_o),
      .error_pc_o       (error_pc_o)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   trace_rec_t  m_q[$];
   logic [31:0] m_retired;
   logic        m_ovf;
   logic        m_err;
   int          m_code;
   logic [31:0] m_epc;
   logic [31:0] m_exp_pc;

   function automatic int rule_code(input logic [31:0] pc, input logic [31:0] wd,
                                    input logic [4:0] rd, input logic [31:0] rdw,
                                    input logic [3:0] m, input logic [31:0] expect_pc);
      if (pc != expect_pc)                return 1;
      if (rd == 0 && rdw != 0)            return 2;
      if (pc % 4 != 0 || wd % 4 != 0)    return 3;
      if (!(m inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                      4'b0011, 4'b1100, 4'b1111})) return 4;
      return 0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_retired = 0;
      m_ovf     = 0;
      m_err     = 0;
      m_code    = 0;
      m_epc     = 0;
      m_exp_pc  = 32'h0;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst || clear_i) begin
         model_reset();
      end else begin
         bit was_full;
         bit popped;
         int code;
         trace_rec_t r;
         was_full = (m_q.size() == DEPTH);
         popped   = (m_q.size() > 0) && trc_ready_i;
         if (popped) void'(m_q.pop_front());
         if (rvfi_valid_i) begin
            m_retired = m_retired + 1;
            if (!m_err) begin
               code = rule_code(rvfi_pc_rdata_i, rvfi_pc_wdata_i, rvfi_rd_addr_i,
                                rvfi_rd_wdata_i, rvfi_mem_wmask_i, m_exp_pc);
               if (code != 0) begin
                  m_err  = 1;
                  m_code = code;
                  m_epc  = rvfi_pc_rdata_i;
               end
            end
            m_exp_pc = rvfi_pc_wdata_i;
            r = '{rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_addr_i, rvfi_rd_wdata_i};
            if (!was_full || popped) m_q.push_back(r);
            else                     m_ovf = 1;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      check("trc_valid", trc_valid_o, m_q.size() != 0);
      if (m_q.size() != 0) check("trc_data", trc_data_o, m_q[0]);
      check("retired", retired_o, m_retired);
      check("overflow", overflow_o, m_ovf);
      check("error", error_o, m_err);
      check("error_code", error_code_o, m_code[2:0]);
      check("error_pc", error_pc_o, m_epc);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] wd,
                         input logic [4:0] rd = 5'd1, input logic [31:0] rdw = 32'h1,
                         input logic [3:0] m = 4'b0000);
      rvfi_valid_i     = 1'b1;
      rvfi_insn_i      = $urandom;
      rvfi_pc_rdata_i  = pc;
      rvfi_pc_wdata_i  = wd;
      rvfi_rd_addr_i   = rd;
      rvfi_rd_wdata_i  = rdw;
      rvfi_mem_wmask_i = m;
      tick();
      rvfi_valid_i     = 1'b0;
   endtask

   task automatic idle();
      rvfi_valid_i = 1'b0;
      tick();
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   initial begin
      int n;
      logic [31:0] pc;
      logic [31:0] nxt;
      rst = 1'b1;
      clear_i = 1'b0;
      rvfi_valid_i = 1'b0;
      rvfi_insn_i = '0;
      rvfi_pc_rdata_i = '0;
      rvfi_pc_wdata_i = '0;
      rvfi_rd_addr_i = '0;
      rvfi_rd_wdata_i = '0;
      rvfi_mem_wmask_i = '0;
      trc_ready_i = 1'b1;
      repeat (2) tick();
      check("rst_retired", retired_o, 0);
      check("rst_valid", trc_valid_o, 0);
      check("rst_error", error_o, 0);
      rst = 1'b0;
      tick();

      // Chained retirements 0,4,8,C,10 with ready high.
      retire(32'h0, 32'h4);
      check("chain_head0_pc", trc_data_o[100:69], 32'h0);
      retire(32'h4, 32'h8);
      check("chain_head1_pc", trc_data_o[100:69], 32'h4);
      retire(32'h8, 32'hC);
      retire(32'hC, 32'h10);
      retire(32'h10, 32'h14);
      idle();
      check("chain_retired", retired_o, 5);
      check("chain_error", error_o, 0);

      // PC chain break, then a later x0 write does not overwrite the code.
      do_clear();
      retire(32'h0, 32'h10);
      retire(32'h8, 32'hC);
      check("pcchain_err", error_o, 1);
      check("pcchain_code", error_code_o, 3'd1);
      check("pcchain_pc", error_pc_o, 32'h8);
      retire(32'hC, 32'h10, 5'd0, 32'h7);
      check("pcchain_frozen", error_code_o, 3'd1);

      // x0 write and illegal mask together: x0 wins.
      do_clear();
      retire(32'h0, 32'h4, 5'd0, 32'h5, 4'b0101);
      check("prio_code", error_code_o, 3'd2);
      retire(32'h40, 32'h44);
      check("prio_frozen", error_code_o, 3'd2);

      // Overflow: DEPTH+3 retirements with ready low, then drain.
      do_clear();
      trc_ready_i = 1'b0;
      for (int i = 0; i < DEPTH + 3; i++) retire(32'(i * 4), 32'(i * 4 + 4));
      check("ovf_flag", overflow_o, 1);
      check("ovf_retired", retired_o, DEPTH + 3);
      trc_ready_i = 1'b1;
      n = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         if (trc_valid_o) n++;
         idle();
      end
      check("ovf_drained", n, DEPTH);

      // Full FIFO with simultaneous push and pop.
      do_clear();
      trc_ready_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) retire(32'(i * 4), 32'(i * 4 + 4));
      trc_ready_i = 1'b1;
      for (int i = DEPTH; i < DEPTH + 4; i++) retire(32'(i * 4), 32'(i * 4 + 4));
      check("pushpop_ovf", overflow_o, 0);
      n = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         if (trc_valid_o) n++;
         idle();
      end
      check("pushpop_count", n, DEPTH);

      // Counter wrap.
      do_clear();
      force dut.retired_q = 32'hFFFF_FFFF;
      m_retired = 32'hFFFF_FFFF;
      idle();
      release dut.retired_q;
      retire(32'h0, 32'h4);
      check("wrap_retired", retired_o, 32'h0);

      // Asynchronous reset in the middle of a burst.
      trc_ready_i = 1'b0;
      retire(32'h4, 32'h8);
      retire(32'h8, 32'h4);
      retire(32'h5, 32'h8);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", trc_valid_o, 0);
      check("arst_retired", retired_o, 0);
      check("arst_ovf", overflow_o, 0);
      check("arst_err", {error_o, error_code_o, error_pc_o}, 0);
      check("arst_data", trc_data_o, 0);
      tick();
      rst = 1'b0;
      tick();

      // Clear beats a retirement in the same cycle; monitor returns to IDLE.
      trc_ready_i = 1'b1;
      clear_i = 1'b1;
      retire(32'h40, 32'h45, 5'd0, 32'h9, 4'b0111);
      clear_i = 1'b0;
      check("clr_retired", retired_o, 0);
      check("clr_valid", trc_valid_o, 0);
      check("clr_err", error_o, 0);
      retire(32'h0, 32'h4);
      check("clr_idle_ok", error_o, 0);
      check("clr_count", retired_o, 1);

      // Randomized traffic.
      do_clear();
      pc = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] legal [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                   4'b1000, 4'b0011, 4'b1100, 4'b1111};
         trc_ready_i = ($urandom_range(0, 3) != 0);
         clear_i = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 2) != 0) begin
            logic [31:0] cur;
            logic [4:0]  rd;
            logic [31:0] rdw;
            logic [3:0]  m;
            cur = ($urandom_range(0, 39) == 0) ? $urandom : pc;
            nxt = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : cur + 32'd4;
            if ($urandom_range(0, 49) == 0) nxt = nxt | 32'h2;
            rd  = 5'($urandom);
            rdw = (rd == 0 && $urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            m   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : legal[$urandom_range(0, 7)];
            pc  = clear_i ? 32'h0 : nxt;
            retire(cur, nxt, rd, rdw, m);
         end else begin
            if (clear_i) pc = 32'h0;
            idle();
         end
         clear_i = 1'b0;
      end
      trc_ready_i = 1'b1;
      repeat (DEPTH + 2) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
